// File: rtl/mmio_uart_tx_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mmio_uart_tx_if
// Brief    : CPU load/store bus seen by the memory-mapped UART transmitter.
// Revision : 1.0  initial release
// ============================================================================
interface mmio_uart_tx_if;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        sel;

  modport master (
    output mem_we, mem_addr, mem_wdata,
    input  mem_rdata, sel
  );

  modport slave (
    input  mem_we, mem_addr, mem_wdata,
    output mem_rdata, sel
  );
endinterface
`default_nettype wire

// File: rtl/mmio_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mmio_uart_tx
// Brief    : Memory-mapped 8N1 UART transmitter with TX FIFO and baud divider.
// Revision : 1.0  initial release
// ============================================================================
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
  input  logic           clk,
  input  logic           rst_n,
  mmio_uart_tx_if.slave  bus,
  output logic           o_tx,
  output logic           o_tx_busy
);

  localparam int c_ADDR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W  = c_ADDR_W + 1;
  localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  logic [7:0]          r_mem [FIFO_DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0]  r_count;
  logic                r_ovf;
  logic [15:0]         r_div;

  state_t              r_state;
  logic [15:0]         r_baud;
  logic [15:0]         r_div_l;
  logic [7:0]          r_shift;
  logic [2:0]          r_bit_idx;
  logic                r_tx;

  logic                w_sel;
  logic [3:0]          w_off;
  logic                w_wr_txdata;
  logic                w_wr_status;
  logic                w_wr_div;
  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic [7:0]          w_head;
  logic [31:0]         w_status;

  assign w_sel       = (bus.mem_addr[31:4] == BASE_ADDR[31:4]);
  assign w_off       = bus.mem_addr[3:0];
  assign w_wr_txdata = bus.mem_we && w_sel && (w_off == 4'h0);
  assign w_wr_status = bus.mem_we && w_sel && (w_off == 4'h4);
  assign w_wr_div    = bus.mem_we && w_sel && (w_off == 4'h8);

  assign w_full  = (r_count == c_FULL);
  assign w_empty = (r_count == '0);
  assign w_push  = w_wr_txdata && !w_full;
  assign w_head  = r_mem[r_rd_ptr];
  // A new byte is taken either from idle or at the last cycle of a stop bit.
  assign w_pop   = !w_empty && ((r_state == S_IDLE) ||
                                ((r_state == S_STOP) && (r_baud == 16'd0)));

  assign o_tx      = r_tx;
  assign o_tx_busy = (r_state != S_IDLE);

  assign w_status = {22'b0, r_ovf, o_tx_busy, w_full, w_empty, 6'(r_count)};

  always_comb begin
    bus.mem_rdata = 32'h0;
    if (w_sel) begin
      case (w_off)
        4'h4:    bus.mem_rdata = w_status;
        4'h8:    bus.mem_rdata = {16'h0, r_div};
        default: bus.mem_rdata = 32'h0;
      endcase
    end
  end
  assign bus.sel = w_sel;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.mem_wdata[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_div    <= DEFAULT_DIV;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_wr_txdata && w_full)
        r_ovf <= 1'b1;
      else if (w_wr_status && bus.mem_wdata[9])
        r_ovf <= 1'b0;
      if (w_wr_div)
        r_div <= (bus.mem_wdata[15:0] == 16'd0) ? 16'd1 : bus.mem_wdata[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_baud    <= 16'd0;
      r_div_l   <= DEFAULT_DIV;
      r_shift   <= 8'h00;
      r_bit_idx <= 3'd0;
      r_tx      <= 1'b1;
    end else if (w_pop) begin
      r_shift <= w_head;
      r_div_l <= r_div;
      r_baud  <= r_div - 16'd1;
      r_tx    <= 1'b0;
      r_state <= S_START;
    end else begin
      case (r_state)
        S_IDLE: r_tx <= 1'b1;
        S_START: begin
          if (r_baud == 16'd0) begin
            r_baud    <= r_div_l - 16'd1;
            r_bit_idx <= 3'd0;
            r_tx      <= r_shift[0];
            r_state   <= S_DATA;
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        S_DATA: begin
          if (r_baud == 16'd0) begin
            r_baud <= r_div_l - 16'd1;
            if (r_bit_idx == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= S_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end else begin
            r_baud <= r_baud - 16'd1;
          end
        end
        S_STOP: begin
          if (r_baud == 16'd0) r_state <= S_IDLE;
          else                 r_baud  <= r_baud - 16'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mmio_uart_tx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mmio_uart_tx
// Brief    : Directed + randomized self-checking bench for mmio_uart_tx.
// Revision : 1.0  initial release
// ============================================================================
module tb_mmio_uart_tx;

  localparam logic [31:0] A_TX = 32'h0000_1000;
  localparam logic [31:0] A_ST = 32'h0000_1004;
  localparam logic [31:0] A_BD = 32'h0000_1008;
  localparam int          DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic tx;
  logic busy;

  always #5 clk = ~clk;

  mmio_uart_tx_if bus();

  mmio_uart_tx #(
    .BASE_ADDR   (32'h0000_1000),
    .FIFO_DEPTH  (DEPTH),
    .DEFAULT_DIV (16'd434)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .o_tx      (tx),
    .o_tx_busy (busy)
  );

  int n_err = 0;
  int n_chk = 0;
  bit q_tx[$];
  bit q_busy[$];

  // One sample of the serial line per cycle, taken mid-cycle.
  always @(negedge clk) begin
    q_tx.push_back(tx);
    q_busy.push_back(busy);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.mem_we    = 1'b1;
    bus.mem_addr  = a;
    bus.mem_wdata = d;
    @(posedge clk);
    #1;
    bus.mem_we    = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.mem_addr = a;
    #1;
    d = bus.mem_rdata;
  endtask

  function automatic logic [31:0] status_word(input bit ovf, input bit b, input int count);
    return (32'(ovf) << 9) | (32'(b) << 8) | (32'(count == DEPTH) << 7) |
           (32'(count == 0) << 6) | 32'(count);
  endfunction

  task automatic wait_idle(input string tag, input int maxc);
    int n = 0;
    tick(2);
    while (busy && n < maxc) begin
      tick(1);
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < maxc), 32'd1);
    tick(2);
  endtask

  // Reference: each frame is 10 slots of d cycles: 0, data LSB first, 1.
  task automatic check_stream(input string tag, input int n0, input bit lat,
                              input logic [7:0] b[$], input int d[$]);
    int idx = -1;
    for (int i = n0; i < q_tx.size(); i++) begin
      if (!q_tx[i]) begin
        idx = i;
        break;
      end
    end
    chk({tag, "_start"}, 32'(idx >= 0), 32'd1);
    if (idx < 0) return;
    if (lat) chk({tag, "_latency"}, 32'(idx - n0), 32'd2);
    for (int k = 0; k < b.size(); k++) begin
      int mism = 0;
      for (int c = 0; c < 10 * d[k]; c++) begin
        int s = c / d[k];
        bit e = (s == 0) ? 1'b0 : (s == 9) ? 1'b1 : b[k][s-1];
        if (idx + c >= q_tx.size()) mism++;
        else if (q_tx[idx+c] !== e || q_busy[idx+c] !== 1'b1) mism++;
      end
      chk($sformatf("%s_frame%0d", tag, k), 32'(mism), 32'd0);
      idx += 10 * d[k];
    end
    if (idx < q_tx.size())
      chk({tag, "_tail"}, {30'd0, q_tx[idx], q_busy[idx]}, 32'd2);
    else
      chk({tag, "_tail_missing"}, 32'(idx), 32'(q_tx.size()));
  endtask

  initial begin
    logic [31:0] r;
    logic [7:0]  qb[$];
    int          qd[$];
    int          n0;
    int          dv;
    logic [7:0]  by;
    logic [7:0]  b1;
    logic [7:0]  b2;
    int          zeros;

    bus.mem_we    = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;

    // Reset state
    tick(3);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    rd(A_ST, r); chk("rst_status", r, status_word(0, 0, 0));
    rd(A_BD, r); chk("rst_bauddiv", r, 32'd434);
    rst_n = 1'b1;
    tick(2);

    // Address decode
    rd(32'h0000_2004, r); chk("nosel_rdata", r, 32'h0);
    chk("nosel_sel", 32'(bus.sel), 32'd0);
    rd(A_TX, r); chk("txdata_read", r, 32'h0);
    chk("sel", 32'(bus.sel), 32'd1);
    rd(32'h0000_100C, r); chk("hole_read", r, 32'h0);
    tick(1);

    // Single frame 0x55 at div 4
    wr(A_BD, 32'd4);
    n0 = q_tx.size();
    wr(A_TX, 32'h55);
    wait_idle("t2", 200);
    qb = {8'h55}; qd = {4};
    check_stream("t2", n0, 1'b1, qb, qd);

    // Random single frames at random divisors
    for (int k = 0; k < 3; k++) begin
      dv = $urandom_range(1, 5);
      by = 8'($urandom);
      wr(A_BD, 32'(dv));
      n0 = q_tx.size();
      wr(A_TX, {24'h0, by});
      wait_idle($sformatf("rnd%0d", k), 200);
      qb = {by}; qd = {dv};
      check_stream($sformatf("rnd%0d", k), n0, 1'b1, qb, qd);
    end

    // Overflow: filler frame busy, then 17 back-to-back stores
    wr(A_BD, 32'd2);
    n0 = q_tx.size();
    wr(A_TX, 32'hA5);
    for (int i = 0; i < 17; i++) wr(A_TX, 32'(i));
    rd(A_ST, r); chk("ovf_status", r, status_word(1, 1, DEPTH));
    wr(A_ST, 32'h200);
    rd(A_ST, r); chk("ovf_clear", r, status_word(0, 1, DEPTH));
    wait_idle("t3", 2000);
    qb = {8'hA5}; qd = {2};
    for (int i = 0; i < 16; i++) begin
      qb.push_back(8'(i));
      qd.push_back(2);
    end
    check_stream("t3", n0, 1'b1, qb, qd);
    rd(A_ST, r); chk("drained_status", r, status_word(0, 0, 0));

    // Divisor change mid-frame applies to the next frame only
    wr(A_BD, 32'd4);
    b1 = 8'($urandom);
    b2 = 8'($urandom);
    n0 = q_tx.size();
    wr(A_TX, {24'h0, b1});
    wr(A_TX, {24'h0, b2});
    tick(8);
    wr(A_BD, 32'd8);
    wait_idle("t5", 500);
    qb = {b1, b2}; qd = {4, 8};
    check_stream("t5", n0, 1'b1, qb, qd);

    // Reset during data bit 3 with three bytes queued
    wr(A_BD, 32'd4);
    wr(A_TX, 32'hF0);
    wr(A_TX, 32'h11);
    wr(A_TX, 32'h22);
    wr(A_TX, 32'h33);
    tick(14);
    chk("pre_rst_tx_bit3", 32'(tx), 32'd0);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rd(A_ST, r); chk("pre_rst_status", r, status_word(0, 1, 3));
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    rd(A_ST, r); chk("midrst_status", r, status_word(0, 0, 0));
    tick(2);
    rst_n = 1'b1;
    tick(1);
    n0 = q_tx.size();
    tick(200);
    zeros = 0;
    for (int i = n0; i < q_tx.size(); i++) if (!q_tx[i]) zeros++;
    chk("post_rst_no_frames", 32'(zeros), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    rd(A_BD, r); chk("post_rst_bauddiv", r, 32'd434);
    tick(1);
    wr(A_BD, 32'h0);
    rd(A_BD, r); chk("bauddiv_zero", r, 32'd1);
    tick(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
